button_event_latch: RTL and testbench
=====================================

BUTTON_EVENT_LATCH -- requirements
Module: button_event_latch

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 500000, meaning the number of consecutive stable synchronized samples required to accept a level change (10 ms at 50 MHz).
REQ-002 SHALL have parameter BTN_AD, default 32'h11180000, meaning the read address of the status register.
REQ-003 SHALL have parameter BTN_CLR_AD, default 32'h111C0000, meaning the write-1-to-clear address for event bits.
REQ-004 SHALL have parameter BTN_MASK_AD, default 32'h11200000, meaning the read/write address of the interrupt mask register.
REQ-005 SHALL have port CLK, input, 1 bit: system clock (50 MHz); the block has one clock.
REQ-006 SHALL have port RST, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port BTN_IN, input, 4 bits: raw asynchronous buttons, with [0]=L, [1]=R, [2]=U, [3]=D.
REQ-008 SHALL have port IOBUS_ADDR, input, 32 bits: bus address.
REQ-009 SHALL have port IOBUS_OUT, input, 32 bits: bus write data.
REQ-010 SHALL have port IOBUS_WR, input, 1 bit: bus write strobe.
REQ-011 SHALL have port RD_DATA, output, 32 bits: read data, combinational from IOBUS_ADDR.
REQ-012 SHALL have port INTR, output, 1 bit: level interrupt request.

Function
REQ-013 Each BTN_IN bit SHALL pass through a two-flop synchronizer before any other use.
REQ-014 Each button SHALL have its own FSM with states LOW, WAIT_HIGH, HIGH, WAIT_LOW and a counter wide enough to hold DEBOUNCE_CYCLES.
REQ-015 In LOW, a synchronized 1 SHALL move the FSM to WAIT_HIGH with the counter set to 1.
REQ-016 In WAIT_HIGH, each synchronized 1 SHALL increment the counter.
REQ-017 In WAIT_HIGH, reaching DEBOUNCE_CYCLES SHALL move the FSM to HIGH and SHALL raise the debounced level.
REQ-018 In WAIT_HIGH, any synchronized 0 SHALL return the FSM to LOW with the counter cleared.
REQ-019 HIGH, WAIT_LOW and the return to LOW SHALL behave symmetrically to REQ-015..REQ-018, lowering the debounced level on acceptance.
REQ-020 The debounced level SHALL rise exactly DEBOUNCE_CYCLES+2 rising edges after the first edge on which BTN_IN is sampled high, given the input is held; release timing SHALL be symmetric.
REQ-021 The LOW/WAIT_HIGH -> HIGH transition SHALL assert a one-cycle press pulse, and that pulse SHALL set sticky event bit EVT[i].
REQ-022 Release SHALL NOT set EVT.
REQ-023 A write to BTN_CLR_AD SHALL clear every EVT[i] whose IOBUS_OUT[i] is 1 on that edge; bits written 0 SHALL be unchanged.
REQ-024 If a press pulse and a clear of the same bit occur on the same edge, the set SHALL win and EVT[i] SHALL be 1.
REQ-025 A write to BTN_MASK_AD SHALL load MASK[3:0] from IOBUS_OUT[3:0].
REQ-026 Writes to any other address, and writes with IOBUS_WR=0, SHALL have no effect.
REQ-027 RD_DATA at BTN_AD SHALL be {24'b0, EVT[3:0], LEVEL[3:0]}.
REQ-028 RD_DATA at BTN_MASK_AD SHALL be {28'b0, MASK}.
REQ-029 RD_DATA at any other address SHALL be 32'b0.
REQ-030 INTR SHALL be the registered value of |(EVT & MASK), asserting one cycle after the EVT set edge.
REQ-031 INTR SHALL remain asserted until the relevant EVT bits are cleared or masked.
REQ-032 Reads SHALL have no side effects.

Reset
REQ-033 When RST=1 at a CLK edge, the synchronizers, LEVEL, EVT, MASK, INTR and all counters SHALL be 0 and every FSM SHALL be in LOW.
REQ-034 RST asserted mid-debounce SHALL abort the debounce without generating a press pulse.
REQ-035 A button held through reset release SHALL be re-debounced from LOW and SHALL then set EVT.

Structure
REQ-036 The FSM state enum and the address constants (BTN_AD, BTN_CLR_AD, BTN_MASK_AD) SHALL live in shared package otter_io_pkg.
REQ-037 The per-button synchronizer plus FSM plus counter SHALL be sub-module btn_debounce_fsm, instantiated four times via a generate loop.

Verification (DEBOUNCE_CYCLES=4)
REQ-038 Bench SHALL check: BTN_IN=4'b0001 held -> LEVEL[0]=1 and RD_DATA@BTN_AD=32'h11 exactly 6 edges after first high sample.
REQ-039 Bench SHALL check: BTN_IN[1] high for 3 cycles, then low -> RD_DATA@BTN_AD stays 32'h0.
REQ-040 Bench SHALL check: MASK=4'b0100 with press on [2] -> INTR=1 one cycle after EVT[2]; then write 32'h4 to BTN_CLR_AD -> EVT[2]=0 and INTR=0 on the following edge.
REQ-041 Bench SHALL check: press pulse [3] coincident with a write of 32'h8 to BTN_CLR_AD -> EVT[3]=1.
REQ-042 Bench SHALL check: RST asserted while BTN_IN[0] is in WAIT_HIGH with count 3 -> all outputs 0; button held -> EVT[0]=1 six edges after RST deasserts.
REQ-043 Bench SHALL check: write 32'hFF to BTN_MASK_AD -> read returns 32'hF; write to 32'h11080000 -> MASK and EVT unchanged.

Source files
------------

// File: rtl/otter_io_pkg.sv
// -----------------------------------------------------------------------------
// otter_io_pkg
// Shared definitions for the OTTER button I/O block:
//   - btn_state_t      : per-button debounce FSM state
//   - BTN_AD           : read address of the button status register
//   - BTN_CLR_AD       : write-1-to-clear address for the sticky event bits
//   - BTN_MASK_AD      : read/write address of the interrupt mask register
//   - btn_status_word  : packs event and level bits into the status word
// -----------------------------------------------------------------------------
package otter_io_pkg;

   typedef enum logic [1:0] {
      LOW       = 2'd0,
      WAIT_HIGH = 2'd1,
      HIGH      = 2'd2,
      WAIT_LOW  = 2'd3
   } btn_state_t;

   localparam int          NUM_BTNS    = 4;
   localparam logic [31:0] BTN_AD      = 32'h1118_0000;
   localparam logic [31:0] BTN_CLR_AD  = 32'h111C_0000;
   localparam logic [31:0] BTN_MASK_AD = 32'h1120_0000;

   function automatic logic [31:0] btn_status_word(input logic [3:0] evt,
                                                   input logic [3:0] level);
      return {24'b0, evt, level};
   endfunction

endpackage

// File: rtl/btn_debounce_fsm.sv
// -----------------------------------------------------------------------------
// btn_debounce_fsm
// One button: two-flop synchronizer followed by a LOW/WAIT_HIGH/HIGH/WAIT_LOW
// debounce FSM. A level change is accepted once the synchronized input has
// disagreed with the current level for DEBOUNCE_CYCLES+1 consecutive samples
// (the sample that opens the wait plus DEBOUNCE_CYCLES more).
//
// Ports
//   CLK     in   system clock
//   RST     in   synchronous active-high reset
//   btn_raw in   raw asynchronous button input
//   level   out  registered debounced level
//   press   out  one-cycle strobe, high in the cycle whose closing edge
//                raises level (decoded so the sticky event bit and level
//                update on the same edge)
// -----------------------------------------------------------------------------
module btn_debounce_fsm
   import otter_io_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic CLK,
   input  logic RST,
   input  logic btn_raw,
   output logic level,
   output logic press
);

   localparam int                CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

   logic [1:0]       sync;   // [0] first stage, [1] second stage
   logic             s;
   btn_state_t       state;
   logic [CNT_W-1:0] count;

   assign s = sync[1];

   // Reset is excluded so an edge that resets the FSM never reports a press.
   assign press = !RST && (state == WAIT_HIGH) && s && (count == CNT_MAX);

   // NOTE: every register in this block updates with <= so all of them
   // sample the values from before the edge, as real flops do.
   always_ff @(posedge CLK) begin
      if (RST) begin
         sync  <= 2'b00;
         state <= LOW;
         count <= '0;
         level <= 1'b0;
      end else begin
         sync <= {sync[0], btn_raw};
         case (state)
            LOW: begin
               if (s) begin
                  state <= WAIT_HIGH;
                  count <= CNT_ONE;
               end
            end
            WAIT_HIGH: begin
               if (!s) begin
                  state <= LOW;
                  count <= '0;
               end else if (count == CNT_MAX) begin
                  state <= HIGH;
                  count <= '0;
                  level <= 1'b1;
               end else begin
                  count <= count + CNT_ONE;
               end
            end
            HIGH: begin
               if (!s) begin
                  state <= WAIT_LOW;
                  count <= CNT_ONE;
               end
            end
            WAIT_LOW: begin
               if (s) begin
                  state <= HIGH;
                  count <= '0;
               end else if (count == CNT_MAX) begin
                  state <= LOW;
                  count <= '0;
                  level <= 1'b0;
               end else begin
                  count <= count + CNT_ONE;
               end
            end
            default: begin
               state <= LOW;
               count <= '0;
            end
         endcase
      end
   end

endmodule

// File: rtl/button_event_latch.sv
// -----------------------------------------------------------------------------
// button_event_latch
// Four debounced buttons with sticky press-event bits, an interrupt mask and
// a level interrupt, exposed on the OTTER I/O bus.
//
// Ports
//   CLK         in   system clock (50 MHz)
//   RST         in   synchronous active-high reset
//   BTN_IN      in   raw buttons [0]=L [1]=R [2]=U [3]=D
//   IOBUS_ADDR  in   bus address
//   IOBUS_OUT   in   bus write data
//   IOBUS_WR    in   bus write strobe
//   RD_DATA     out  combinational read data for IOBUS_ADDR
//                      BTN_AD      -> {24'b0, EVT, LEVEL}
//                      BTN_MASK_AD -> {28'b0, MASK}
//                      otherwise   -> 0
//   INTR        out  registered |(EVT & MASK)
// Writes: BTN_CLR_AD clears EVT bits written 1 (a same-edge press wins);
//         BTN_MASK_AD loads MASK from IOBUS_OUT[3:0].
// -----------------------------------------------------------------------------
module button_event_latch
   import otter_io_pkg::*;
#(
   parameter int          DEBOUNCE_CYCLES = 500000,
   parameter logic [31:0] BTN_AD          = otter_io_pkg::BTN_AD,
   parameter logic [31:0] BTN_CLR_AD      = otter_io_pkg::BTN_CLR_AD,
   parameter logic [31:0] BTN_MASK_AD     = otter_io_pkg::BTN_MASK_AD
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [3:0]  BTN_IN,
   input  logic [31:0] IOBUS_ADDR,
   input  logic [31:0] IOBUS_OUT,
   input  logic        IOBUS_WR,
   output logic [31:0] RD_DATA,
   output logic        INTR
);

   logic [NUM_BTNS-1:0] level;
   logic [NUM_BTNS-1:0] press;
   logic [NUM_BTNS-1:0] evt;
   logic [NUM_BTNS-1:0] mask;
   logic                clr_wr;
   logic                mask_wr;
   logic                unused_wdata;

   // Only the low nibble of write data is meaningful to this block.
   assign unused_wdata = ^IOBUS_OUT[31:NUM_BTNS];

   for (genvar i = 0; i < NUM_BTNS; i++) begin : gen_btn
      btn_debounce_fsm #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debounce (
         .CLK    (CLK),
         .RST    (RST),
         .btn_raw(BTN_IN[i]),
         .level  (level[i]),
         .press  (press[i])
      );
   end

   assign clr_wr  = IOBUS_WR && (IOBUS_ADDR == BTN_CLR_AD);
   assign mask_wr = IOBUS_WR && (IOBUS_ADDR == BTN_MASK_AD);

   always_ff @(posedge CLK) begin
      if (RST) begin
         evt  <= '0;
         mask <= '0;
         INTR <= 1'b0;
      end else begin
         // OR-ing press after the clear makes a coincident press win.
         if (clr_wr)
            evt <= (evt & ~IOBUS_OUT[NUM_BTNS-1:0]) | press;
         else
            evt <= evt | press;
         if (mask_wr)
            mask <= IOBUS_OUT[NUM_BTNS-1:0];
         INTR <= |(evt & mask);
      end
   end

   // NOTE: the default assignment first means every path drives RD_DATA,
   // so this stays pure combinational logic with no inferred latch.
   always_comb begin
      RD_DATA = 32'b0;
      if (IOBUS_ADDR == BTN_AD)
         RD_DATA = btn_status_word(evt, level);
      else if (IOBUS_ADDR == BTN_MASK_AD)
         RD_DATA = {28'b0, mask};
   end

endmodule

// File: tb/tb_button_event_latch.sv
module tb_button_event_latch;
   import otter_io_pkg::*;

   localparam int          DB    = 4;
   localparam logic [31:0] OTHER = 32'h1108_0000;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic [3:0]  BTN_IN = 4'b0;
   logic [31:0] IOBUS_ADDR = 32'b0;
   logic [31:0] IOBUS_OUT = 32'b0;
   logic        IOBUS_WR = 1'b0;
   logic [31:0] RD_DATA;
   logic        INTR;

   int checks = 0;
   int failures = 0;

   button_event_latch #(
      .DEBOUNCE_CYCLES(DB)
   ) dut (
      .CLK       (CLK),
      .RST       (RST),
      .BTN_IN    (BTN_IN),
      .IOBUS_ADDR(IOBUS_ADDR),
      .IOBUS_OUT (IOBUS_OUT),
      .IOBUS_WR  (IOBUS_WR),
      .RD_DATA   (RD_DATA),
      .INTR      (INTR)
   );

   always #5 CLK = ~CLK;

   // ---------------- helpers ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
      IOBUS_ADDR = a;
      IOBUS_OUT  = d;
      IOBUS_WR   = 1'b1;
      step(1);
      IOBUS_WR   = 1'b0;
   endtask

   task automatic check_rd(input string name, input logic [31:0] a, input logic [31:0] exp);
      IOBUS_ADDR = a;
      #1;
      check(name, RD_DATA, exp);
   endtask

   task automatic check_intr(input string name, input logic exp);
      check(name, {31'b0, INTR}, {31'b0, exp});
   endtask

   // ---------------- reference model ----------------
   // A level flips once the synchronized input (raw delayed by two edges)
   // has disagreed with it for DB+1 consecutive edges; rising flips are presses.
   logic [3:0] m_lvl, m_evt, m_mask, m_d1, m_d2;
   logic       m_intr;
   int         m_run[4];

   task automatic model_reset();
      m_lvl = '0; m_evt = '0; m_mask = '0; m_d1 = '0; m_d2 = '0; m_intr = 1'b0;
      for (int i = 0; i < 4; i++) m_run[i] = 0;
   endtask

   task automatic model_step(input logic [3:0] btn, input logic wr,
                             input logic [31:0] a, input logic [31:0] d);
      logic [3:0] press;
      logic       nintr;
      press = '0;
      nintr = |(m_evt & m_mask);
      for (int i = 0; i < 4; i++) begin
         if (m_d2[i] != m_lvl[i]) begin
            m_run[i]++;
            if (m_run[i] == DB + 1) begin
               m_lvl[i] = ~m_lvl[i];
               m_run[i] = 0;
               press[i] = m_lvl[i];
            end
         end else begin
            m_run[i] = 0;
         end
      end
      m_d2 = m_d1;
      m_d1 = btn;
      if (wr && a == BTN_CLR_AD) m_evt = (m_evt & ~d[3:0]) | press;
      else                       m_evt = m_evt | press;
      if (wr && a == BTN_MASK_AD) m_mask = d[3:0];
      m_intr = nintr;
   endtask

   function automatic logic [31:0] model_rd(input logic [31:0] a);
      if (a == BTN_AD)      return {24'b0, m_evt, m_lvl};
      if (a == BTN_MASK_AD) return {28'b0, m_mask};
      return 32'b0;
   endfunction

   // ---------------- bus vector table ----------------
   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] data;
      logic [31:0] rd_addr;
      logic [31:0] exp_rd;
      logic        exp_intr;
   } vec_t;

   vec_t vecs[10];

   initial begin
      logic [3:0]  rb;
      logic        rwr;
      logic [31:0] ra, rd;

      // Starting state for the table: EVT=1, LEVEL=1 on button 0, MASK=0.
      vecs[0] = '{1'b1, BTN_MASK_AD, 32'h0000_00FF, BTN_MASK_AD, 32'h0000_000F, 1'b0};
      vecs[1] = '{1'b1, OTHER,       32'hFFFF_FFFF, BTN_MASK_AD, 32'h0000_000F, 1'b1};
      vecs[2] = '{1'b1, OTHER,       32'hFFFF_FFFF, BTN_AD,      32'h0000_0011, 1'b1};
      vecs[3] = '{1'b0, BTN_CLR_AD,  32'h0000_000F, BTN_AD,      32'h0000_0011, 1'b1};
      vecs[4] = '{1'b0, BTN_MASK_AD, 32'h0000_0000, BTN_MASK_AD, 32'h0000_000F, 1'b1};
      vecs[5] = '{1'b1, BTN_MASK_AD, 32'h0000_0003, BTN_MASK_AD, 32'h0000_0003, 1'b1};
      vecs[6] = '{1'b0, BTN_AD,      32'h0000_0000, OTHER,       32'h0000_0000, 1'b1};
      vecs[7] = '{1'b1, BTN_CLR_AD,  32'h0000_000E, BTN_AD,      32'h0000_0011, 1'b1};
      vecs[8] = '{1'b1, BTN_CLR_AD,  32'h0000_0001, BTN_AD,      32'h0000_0001, 1'b1};
      vecs[9] = '{1'b1, BTN_MASK_AD, 32'hFFFF_FFF0, BTN_MASK_AD, 32'h0000_0000, 1'b0};

      // Reset state
      step(3);
      check_rd("reset_status", BTN_AD, 32'h0);
      check_rd("reset_mask", BTN_MASK_AD, 32'h0);
      check_intr("reset_intr", 1'b0);
      RST = 1'b0;

      // Press on [0]: level and event appear exactly 6 edges after the first sample
      BTN_IN = 4'b0001;
      step(6);
      check_rd("press0_early", BTN_AD, 32'h00);
      step(1);
      check_rd("press0_level", BTN_AD, 32'h11);
      BTN_IN = 4'b0000;
      step(6);
      check_rd("release0_early", BTN_AD, 32'h11);
      step(1);
      check_rd("release0_no_evt", BTN_AD, 32'h10);
      bus_write(BTN_CLR_AD, 32'h1);
      check_rd("clear0", BTN_AD, 32'h00);

      // Glitch on [1] shorter than the debounce window
      BTN_IN = 4'b0010;
      step(3);
      BTN_IN = 4'b0000;
      step(10);
      check_rd("glitch1", BTN_AD, 32'h00);
      check_intr("glitch1_intr", 1'b0);

      // Masked press on [2] drives INTR; clear drops it one edge later
      bus_write(BTN_MASK_AD, 32'h4);
      BTN_IN = 4'b0100;
      step(6);
      check_rd("press2_early", BTN_AD, 32'h00);
      step(1);
      check_rd("press2_evt", BTN_AD, 32'h44);
      check_intr("press2_intr_lag", 1'b0);
      step(1);
      check_intr("press2_intr", 1'b1);
      bus_write(BTN_CLR_AD, 32'h4);
      check_rd("clear2_evt", BTN_AD, 32'h04);
      check_intr("clear2_intr_lag", 1'b1);
      step(1);
      check_intr("clear2_intr", 1'b0);
      BTN_IN = 4'b0000;
      step(8);
      check_rd("release2", BTN_AD, 32'h00);

      // Press on [3] coincident with a clear of the same bit: set wins
      BTN_IN = 4'b1000;
      step(6);
      IOBUS_ADDR = BTN_CLR_AD;
      IOBUS_OUT  = 32'h8;
      IOBUS_WR   = 1'b1;
      step(1);
      IOBUS_WR   = 1'b0;
      check_rd("press3_clr_race", BTN_AD, 32'h88);
      check_intr("press3_masked", 1'b0);
      bus_write(BTN_CLR_AD, 32'h8);
      check_rd("clear3", BTN_AD, 32'h08);
      BTN_IN = 4'b0000;
      step(8);
      check_rd("release3", BTN_AD, 32'h00);

      // Reset mid-debounce (count 3) aborts; held button re-debounces after release
      BTN_IN = 4'b0001;
      step(5);
      RST = 1'b1;
      step(1);
      check_rd("midrst_status", BTN_AD, 32'h0);
      check_rd("midrst_mask", BTN_MASK_AD, 32'h0);
      check_intr("midrst_intr", 1'b0);
      RST = 1'b0;
      step(6);
      check_rd("postrst_early", BTN_AD, 32'h00);
      step(1);
      check_rd("postrst_evt", BTN_AD, 32'h11);

      // Table-driven bus accesses
      for (int i = 0; i < 10; i++) begin
         if (vecs[i].wr) begin
            bus_write(vecs[i].addr, vecs[i].data);
         end else begin
            IOBUS_ADDR = vecs[i].addr;
            IOBUS_OUT  = vecs[i].data;
            step(1);
         end
         check_rd($sformatf("vec%0d_rd", i), vecs[i].rd_addr, vecs[i].exp_rd);
         check_intr($sformatf("vec%0d_intr", i), vecs[i].exp_intr);
      end

      // Randomized traffic against the reference model
      RST = 1'b1;
      BTN_IN = 4'b0;
      IOBUS_WR = 1'b0;
      step(2);
      model_reset();
      RST = 1'b0;
      rb = 4'b0;
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < 4; i++)
            if ($urandom_range(0, 9) == 0) rb[i] = ~rb[i];
         rwr = ($urandom_range(0, 3) == 0);
         case ($urandom_range(0, 3))
            0:       ra = BTN_AD;
            1:       ra = BTN_CLR_AD;
            2:       ra = BTN_MASK_AD;
            default: ra = $urandom | 32'h1;
         endcase
         rd = $urandom;
         BTN_IN     = rb;
         IOBUS_WR   = rwr;
         IOBUS_ADDR = ra;
         IOBUS_OUT  = rd;
         #1;
         check($sformatf("rand%0d_rd", c), RD_DATA, model_rd(ra));
         check($sformatf("rand%0d_intr", c), {31'b0, INTR}, {31'b0, m_intr});
         @(posedge CLK);
         #1;
         model_step(rb, rwr, ra, rd);
      end
      IOBUS_WR = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
